// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide engine for MULT/MULTU/DIV/DIVU.
// Magnitudes are formed at launch, WIDTH radix-2 steps run in RUN,
// and sign correction plus the HI/LO write happen in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_cnt;
    logic                     r_is_div;
    logic                     r_neg_q;    // product sign (mult) or quotient sign (div)
    logic                     r_neg_r;    // remainder sign = dividend sign
    logic                     r_dbz;
    logic [WIDTH-1:0]         r_ph;       // accumulator upper half / partial remainder
    logic [WIDTH-1:0]         r_pl;       // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0]         r_opnd;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0]         r_rs_raw;   // untouched dividend for the divide-by-zero HI

    logic signed [WIDTH-1:0]  w_rs_s;
    logic signed [WIDTH-1:0]  w_rt_s;
    logic                     w_signed;
    logic                     w_rs_neg;
    logic                     w_rt_neg;
    logic [WIDTH-1:0]         w_rs_mag;
    logic [WIDTH-1:0]         w_rt_mag;
    logic                     w_accept;
    logic [WIDTH:0]           w_sum;
    logic [WIDTH:0]           w_shift;
    logic                     w_ge;
    logic [WIDTH-1:0]         w_diff;
    logic [2*WIDTH-1:0]       w_prod;
    logic [WIDTH-1:0]         w_quo;
    logic [WIDTH-1:0]         w_rem;

    // Two's-complement negate when neg is set (single width).
    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // Two's-complement negate when neg is set (double width product).
    function automatic logic [2*WIDTH-1:0] f_cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    assign w_rs_s   = rs_val;
    assign w_rt_s   = rt_val;
    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & (w_rs_s < 0);
    assign w_rt_neg = w_signed & (w_rt_s < 0);
    assign w_rs_mag = f_cond_neg(rs_val, w_rs_neg);
    assign w_rt_mag = f_cond_neg(rt_val, w_rt_neg);
    assign w_accept = start && (r_state == S_IDLE);

    // Shift-add step: add multiplicand when the low multiplier bit is set.
    assign w_sum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opnd} : '0);
    // Restoring divide step: bring in the next dividend bit and trial-subtract.
    assign w_shift = {r_ph, r_pl[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

    assign w_prod = f_cond_neg2({r_ph, r_pl}, r_neg_q);
    assign w_quo  = f_cond_neg(r_pl, r_neg_q);
    assign w_rem  = f_cond_neg(r_ph, r_neg_r);

    // Next-state logic for the IDLE -> RUN -> FIX sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, control flags and the architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            r_state     <= w_state_nxt;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mt_hi) hi <= mt_data;
                    if (mt_lo) lo <= mt_data;
                    if (start) begin
                        busy     <= 1'b1;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_is_div <= op[1];
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= op[1] & w_rs_neg;
                        r_dbz    <= op[1] & (rt_val == '0);
                    end
                end
                S_RUN: r_cnt <= r_cnt - 1'b1;
                S_FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= r_dbz;
                    if (r_dbz) begin
                        hi <= r_rs_raw;
                        lo <= '1;
                    end else if (r_is_div) begin
                        hi <= w_rem;
                        lo <= w_quo;
                    end else begin
                        {hi, lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    // Iteration datapath: loaded on accept, one radix-2 step per RUN cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rs_raw <= rs_val;
            r_ph     <= '0;
            if (op[1]) begin
                r_pl   <= w_rs_mag;
                r_opnd <= w_rt_mag;
            end else begin
                r_pl   <= w_rt_mag;
                r_opnd <= w_rs_mag;
            end
        end else if (r_state == S_RUN) begin
            if (r_is_div) begin
                r_ph <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_pl <= {r_pl[WIDTH-2:0], w_ge};
            end else begin
                r_ph <= w_sum[WIDTH:1];
                r_pl <= {w_sum[0], r_pl[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          mt_hi;
    logic          mt_lo;
    logic [W-1:0]  mt_data;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t q_exp[$];
    exp_t last_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_ops    = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .mt_hi      (mt_hi),
        .mt_lo      (mt_lo),
        .mt_data    (mt_data),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model built on 64-bit language arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] u;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            2'b01: begin
                u = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = u;
            end
            default: begin
                if (b == '0) begin
                    e.dbz = 1'b1;
                    e.lo  = '1;
                    e.hi  = a;
                end else if (o == 2'b10) begin
                    sa   = longint'($signed(a));
                    sb   = longint'($signed(b));
                    e.lo = 32'(sa / sb);
                    e.hi = 32'(sa % sb);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        q_exp.push_back(e);
        tick();
        start  = 1'b0;
    endtask

    // Wait for done (bounded), optionally poking start/mt_hi mid-op, then score.
    task automatic finish(input int inject_at);
        int   lat;
        int   bcnt;
        exp_t e;
        string t;
        n_ops++;
        t    = $sformatf("op%0d", n_ops);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            if (lat == inject_at) begin
                start   = 1'b1;
                op      = 2'b01;
                rs_val  = 32'hFFFF_FFFF;
                rt_val  = 32'hFFFF_FFFF;
                mt_hi   = 1'b1;
                mt_data = 32'h0000_DEAD;
            end
            tick();
            lat++;
            start = 1'b0;
            mt_hi = 1'b0;
            if (busy) bcnt++;
        end
        chk({t, "_done_seen"}, done, 1);
        chk({t, "_latency"}, lat, 33);
        chk({t, "_busy_cycles"}, bcnt, 33);
        chk({t, "_sb_nonempty"}, q_exp.size() != 0, 1);
        if (q_exp.size() != 0) begin
            e      = q_exp.pop_front();
            last_e = e;
            chk({t, "_hi"}, hi, e.hi);
            chk({t, "_lo"}, lo, e.lo);
            chk({t, "_dbz"}, div_by_zero, e.dbz);
        end
        tick();
        chk({t, "_done_pulse"}, done, 0);
        chk({t, "_dbz_pulse"}, div_by_zero, 0);
        chk({t, "_busy_after"}, busy, 0);
    endtask

    task automatic run_exp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        exp_t e;
        e.hi  = eh;
        e.lo  = el;
        e.dbz = ed;
        launch(o, a, b, e);
        finish(-1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_val  = '0;
        rt_val  = '0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        mt_data = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rst_n = 1'b1;
        tick();

        run_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_exp(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_exp(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_exp(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_exp(2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        run_exp(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run_exp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_exp(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_exp(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);

        // Same-edge start and MTHI/MTLO: both land, result overwrites later.
        op      = 2'b01;
        rs_val  = 32'd9;
        rt_val  = 32'd11;
        mt_hi   = 1'b1;
        mt_lo   = 1'b1;
        mt_data = 32'h0000_A5A5;
        start   = 1'b1;
        q_exp.push_back(model(2'b01, 32'd9, 32'd11));
        tick();
        start = 1'b0;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        chk("same_edge_mt_hi", hi, 32'h0000_A5A5);
        chk("same_edge_mt_lo", lo, 32'h0000_A5A5);
        finish(-1);

        // Start and MTHI while busy are ignored; MTLO after done lands.
        launch(2'b01, 32'h1234_5678, 32'h10, model(2'b01, 32'h1234_5678, 32'h10));
        finish(5);
        repeat (4) tick();
        chk("hold_hi", hi, last_e.hi);
        chk("hold_lo", lo, last_e.lo);
        chk("hold_busy", busy, 0);
        mt_lo   = 1'b1;
        mt_data = 32'h0000_1234;
        tick();
        mt_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi_kept", hi, last_e.hi);

        // Asynchronous reset mid-run aborts the op immediately.
        launch(2'b01, 32'h0000_0BAD, 32'h0000_BEEF, model(2'b01, 32'h0000_0BAD, 32'h0000_BEEF));
        repeat (10) tick();
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        q_exp.delete();
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", busy, 0);
        run_exp(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // Model-checked mixed operations.
        for (int i = 0; i < 6; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            o = 2'($urandom_range(0, 3));
            a = $urandom();
            b = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300));
            if (i == 3) a = -a;
            launch(o, a, b, model(o, a, b));
            finish(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
